// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, data width and baud divisor helper.
// Used by both the receive and transmit paths.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive byte stream: show-ahead data, valid/ready handshake and FIFO occupancy.
// The producer drives the master side; the consumer drives the slave side.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  import uart_pkg::*;

  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [COUNT_W-1:0]     rx_count;

  modport master (output rx_data, rx_valid, rx_count, input  rx_ready);
  modport slave  (input  rx_data, rx_valid, rx_count, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO with registered pointers and count.
// A write while full is accepted only when a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr, do_rd;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);

  // NOTE: the storage array is deliberately not reset; only pointers and count are,
  // and the read port is masked while empty so stale contents never escape.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop input synchroniser, centre-sampling FSM and a byte FIFO
// presented as a valid/ready stream, with frame-error pulse and sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  uart_rx_fifo_if.master        rx_if,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  overrun_clr
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int COUNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic                   rx_meta_q, rxs_q;
  uart_state_e            state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             bit_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   frame_err_q, overrun_q;

  logic                   tick, push, pop, full, empty, overrun_set;
  logic [COUNT_W-1:0]     count;
  logic [UART_DATA_W-1:0] head;

  // Synchroniser flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  assign tick        = (cnt_q == '0);
  assign push        = (state_q == STOP) && tick && rxs_q;
  assign pop         = !empty && rx_if.rx_ready;
  assign overrun_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (overrun_set)      overrun_q <= 1'b1;
      else if (overrun_clr) overrun_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          bit_q <= '0;
          cnt_q <= '0;
          if (!rxs_q) begin
            state_q <= START;
            cnt_q   <= CNT_W'(HALF_BIT - 1);
          end
        end
        START: begin
          if (!tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rxs_q) begin
            state_q <= IDLE;
          end else begin
            state_q <= DATA;
            cnt_q   <= CNT_W'(CLKS_PER_BIT - 1);
          end
        end
        DATA: begin
          if (!tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {rxs_q, shift_q[UART_DATA_W-1:1]};
            cnt_q   <= CNT_W'(CLKS_PER_BIT - 1);
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (!tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rxs_q) begin
            state_q <= IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= BREAK;
          end
        end
        BREAK: begin
          // Hold here until the line idles so a stuck-low rx cannot spawn frames.
          if (rxs_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (shift_q),
    .rd_en_i   (rx_if.rx_ready),
    .rd_data_o (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign rx_if.rx_data  = head;
  assign rx_if.rx_valid = !empty;
  assign rx_if.rx_count = count;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at the default 12 MHz / 115200 baud (104 clocks per bit).
// Expected values are hand-computed; outputs are sampled on the falling clock edge.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CPB = 104;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic overrun_clr = 1'b0;
  logic frame_err, overrun;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int start_cyc = 0;
  int valid_rise_cyc = -1;
  int fe_rise_cyc = -1;
  int fe_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] popped [$];

  uart_rx_fifo_if #(.FIFO_DEPTH(16)) bus ();

  uart_rx_fifo #(
    .CLK_HZ     (12000000),
    .BAUD       (115200),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_if       (bus),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) begin
      fe_cnt++;
      fe_rise_cyc = cyc;
    end
    if (bus.rx_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = bus.rx_valid;
    if (bus.rx_valid && bus.rx_ready) popped.push_back(bus.rx_data);
  end

  initial begin
    #(600000 * 10);
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 600000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame starting on a falling edge; stop_lvl selects the stop bit level.
  task automatic send_frame(input logic [7:0] data, input logic stop_lvl);
    start_cyc = cyc;
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_clks(CPB);
    end
    rx = stop_lvl;
    wait_clks(CPB);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    bus.rx_ready = 1'b1;
    wait_clks(1);
    bus.rx_ready = 1'b0;
  endtask

  initial begin
    int fe_before;
    bus.rx_ready = 1'b0;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(2);

    // Reset state
    check("reset_valid", bus.rx_valid, 1'b0);
    check("reset_count", bus.rx_count, 5'd0);
    check("reset_data", bus.rx_data, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);

    // Single frame 0xA5, consumer stalled; valid rises 991 cycles after the start edge
    send_frame(8'hA5, 1'b1);
    wait_clks(10);
    check("a5_valid", bus.rx_valid, 1'b1);
    check("a5_data", bus.rx_data, 8'hA5);
    check("a5_count", bus.rx_count, 5'd1);
    check("a5_latency", valid_rise_cyc - start_cyc, 991);
    check("a5_no_frame_err", fe_cnt, 0);
    pop_one();
    check("a5_popped_count", bus.rx_count, 5'd0);
    check("a5_popped_valid", bus.rx_valid, 1'b0);

    // Back-to-back 0x55 then 0x00 with no gap, consumer always ready
    popped.delete();
    bus.rx_ready = 1'b1;
    send_frame(8'h55, 1'b1);
    send_frame(8'h00, 1'b1);
    wait_clks(20);
    bus.rx_ready = 1'b0;
    check("b2b_pop_total", popped.size(), 2);
    if (popped.size() == 2) begin
      check("b2b_first", popped[0], 8'h55);
      check("b2b_second", popped[1], 8'h00);
    end
    check("b2b_count", bus.rx_count, 5'd0);

    // 40-clock low glitch is rejected at the mid-start resample
    rx = 1'b0;
    wait_clks(40);
    rx = 1'b1;
    wait_clks(200);
    check("glitch_count", bus.rx_count, 5'd0);
    check("glitch_no_frame_err", fe_cnt, 0);
    check("glitch_state_idle", dut.state_q, IDLE);

    // Frame 0x3C with a low stop bit, then the line held low for 3000 clocks
    fe_before = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    wait_clks(3000);
    check("break_state", dut.state_q, BREAK);
    rx = 1'b1;
    wait_clks(300);
    check("ferr_pulses", fe_cnt - fe_before, 1);
    check("ferr_timing", fe_rise_cyc - start_cyc, 991);
    check("ferr_no_push", bus.rx_count, 5'd0);
    check("ferr_state_idle", dut.state_q, IDLE);

    // Fill the FIFO with 16 frames, then a 17th overflows
    for (int i = 0; i < 16; i++) send_frame(8'h10 + 8'(i), 1'b1);
    wait_clks(10);
    check("full_count", bus.rx_count, 5'd16);
    check("full_no_overrun", overrun, 1'b0);
    send_frame(8'h20, 1'b1);
    wait_clks(10);
    check("ovr_count", bus.rx_count, 5'd16);
    check("ovr_flag", overrun, 1'b1);
    wait_clks(50);
    check("ovr_sticky", overrun, 1'b1);
    overrun_clr = 1'b1;
    wait_clks(1);
    overrun_clr = 1'b0;
    check("ovr_cleared", overrun, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), bus.rx_data, 8'h10 + 8'(i));
      pop_one();
    end
    check("drain_count", bus.rx_count, 5'd0);
    check("drain_valid", bus.rx_valid, 1'b0);

    // Reset mid-DATA of 0xFF with one byte already buffered
    send_frame(8'h77, 1'b1);
    wait_clks(10);
    check("pre_rst_count", bus.rx_count, 5'd1);
    rx = 1'b0;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(3 * CPB);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(1);
    check("rst_valid", bus.rx_valid, 1'b0);
    check("rst_count", bus.rx_count, 5'd0);
    check("rst_data", bus.rx_data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_state", dut.state_q, IDLE);
    wait_clks(6 * CPB);
    check("rst_no_partial", bus.rx_count, 5'd0);
    send_frame(8'h12, 1'b1);
    wait_clks(10);
    check("post_rst_valid", bus.rx_valid, 1'b1);
    check("post_rst_data", bus.rx_data, 8'h12);
    check("post_rst_count", bus.rx_count, 5'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
